// File: rtl/cla_pkg.sv
`default_nettype none
// cla_pkg -- shared constants and per-bit GPK classification for the CLA adder.
// Rev 1.0
package cla_pkg;

   localparam int ADD_WIDTH = 32;
   localparam int CLA_GROUP = 4;

   typedef enum logic [1:0] {
      KILL      = 2'd0,
      PROPAGATE = 2'd1,
      GENERATE  = 2'd2
   } gpk_t;

   function automatic gpk_t classify_bit(input logic ai, input logic bi);
      if (ai & bi)
         return GENERATE;
      else if (ai ^ bi)
         return PROPAGATE;
      else
         return KILL;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cla_gpk_4.sv
`default_nettype none
// cla_gpk_4 -- 4-bit first-level lookahead: bit carries plus group generate/propagate.
// Rev 1.0
module cla_gpk_4
   import cla_pkg::*;
(
   input  logic [3:0] g,
   input  logic [3:0] p,
   input  logic       cin,
   output logic [3:0] c,
   output logic       G,
   output logic       P
);

   // Every carry is a flat sum of products, so no carry depends on its neighbour.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);

   assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   assign P = &p;

endmodule
`default_nettype wire

// File: rtl/cla_adder_32.sv
`default_nettype none
// cla_adder_32 -- registered two-level carry-lookahead adder, result {carry_out, a+b}.
// Rev 1.0
module cla_adder_32
   import cla_pkg::*;
#(
   parameter int WIDTH = ADD_WIDTH,
   parameter int GROUP = CLA_GROUP
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH:0]   sum,
   output logic             out_valid
);

   localparam int NGROUPS = WIDTH / GROUP;

   gpk_t               bit_state [WIDTH];
   logic [WIDTH-1:0]   g;
   logic [WIDTH-1:0]   p;
   logic [WIDTH-1:0]   c;
   logic [NGROUPS-1:0] grp_g;
   logic [NGROUPS-1:0] grp_p;
   logic [NGROUPS:0]   grp_c;
   logic               prod;
   logic [WIDTH:0]     sum_next;

   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         bit_state[i] = classify_bit(a[i], b[i]);
         g[i]         = (bit_state[i] == GENERATE);
         p[i]         = (bit_state[i] == PROPAGATE);
      end
   end

   // The group unit is fixed at 4 bits, so GROUP is expected to stay at 4.
   generate
      for (genvar j = 0; j < NGROUPS; j++) begin : g_group
         cla_gpk_4 u_gpk (
            .g   (g[j*GROUP +: GROUP]),
            .p   (p[j*GROUP +: GROUP]),
            .cin (grp_c[j]),
            .c   (c[j*GROUP +: GROUP]),
            .G   (grp_g[j]),
            .P   (grp_p[j])
         );
      end
   endgenerate

   // Second level: carry into group j is OR over k<j of G[k] & P[k+1..j-1];
   // grp_c[0] stays 0 since the adder has no carry-in.
   always_comb begin
      grp_c = '0;
      prod  = 1'b0;
      for (int j = 1; j <= NGROUPS; j++) begin
         for (int k = 0; k < j; k++) begin
            prod = grp_g[k];
            for (int m = k + 1; m < j; m++)
               prod = prod & grp_p[m];
            grp_c[j] = grp_c[j] | prod;
         end
      end
   end

   assign sum_next = {grp_c[NGROUPS], p ^ c};

   always_ff @(posedge clk) begin
      if (rst) begin
         sum       <= '0;
         out_valid <= 1'b0;
      end else begin
         sum       <= sum_next;
         out_valid <= in_valid;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cla_adder_32.sv
`default_nettype none
// tb_cla_adder_32 -- scoreboard bench: driver queues expected results, monitor checks each cycle.
// Rev 1.0
module tb_cla_adder_32;

   typedef struct packed {
      logic        v;
      logic [32:0] s;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] a;
   logic [31:0] b;
   logic [32:0] sum;
   logic        out_valid;

   exp_t exp_q [$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   cla_adder_32 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .sum       (sum),
      .out_valid (out_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Directed step: caller supplies the expected registered result.
   task automatic drive(input logic r, input logic v, input logic [31:0] x,
                        input logic [31:0] y, input logic [32:0] e);
      @(negedge clk);
      rst      = r;
      in_valid = v;
      a        = x;
      b        = y;
      exp_q.push_back('{v: (r ? 1'b0 : v), s: (r ? 33'd0 : e)});
   endtask

   // Random step: expected result from plain 33-bit arithmetic.
   task automatic drive_model(input logic r, input logic v, input logic [31:0] x,
                              input logic [31:0] y);
      logic [32:0] e;
      e = {1'b0, x} + {1'b0, y};
      drive(r, v, x, y, e);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            total++;
            if (out_valid !== mon_e.v) begin
               bad++;
               $display("FAIL out_valid cycle=%0d got=%b want=%b", cyc, out_valid, mon_e.v);
            end
            total++;
            if (sum !== mon_e.s) begin
               bad++;
               $display("FAIL sum cycle=%0d got=0x%09h want=0x%09h", cyc, sum, mon_e.s);
            end
         end
      end
   end

   initial begin
      logic [31:0] x;
      logic [31:0] y;
      logic        v;
      logic        r;
      rst      = 1'b1;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;

      // reset holds outputs at zero even with live operands
      drive(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 33'h0_0000_0000);
      drive(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 33'h0_0000_0000);
      drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000);

      drive(1'b0, 1'b1, 32'h0000_0000, 32'h0001_1001, 33'h0_0001_1001);
      drive(1'b0, 1'b1, 32'h0002_1001, 32'h0002_1001, 33'h0_0004_2002);
      drive(1'b0, 1'b1, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 33'h0_FFFF_FFFF);
      drive(1'b0, 1'b1, 32'h0F0F_0F0F, 32'hF0F0_F0F1, 33'h1_0000_0000);
      drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE);
      drive(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 33'h1_0000_0000);
      drive(1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 33'h0_0000_0000);

      // back-to-back, one bubble, then a mid-stream reset
      drive(1'b0, 1'b1, 32'h0000_0001, 32'h0000_0002, 33'h0_0000_0003);
      drive(1'b0, 1'b1, 32'h1234_5678, 32'h8765_4321, 33'h0_9999_9999);
      drive(1'b0, 1'b1, 32'hFFFF_0000, 32'h0001_0000, 33'h1_0000_0000);
      drive(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 33'h0_8000_0000);
      drive(1'b0, 1'b0, 32'h0000_000F, 32'h0000_0001, 33'h0_0000_0010);
      drive(1'b0, 1'b1, 32'h0000_00FF, 32'h0000_0001, 33'h0_0000_0100);
      drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 33'h0_0000_0000);
      drive(1'b0, 1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 33'h0_EFBE_D000);

      for (int i = 0; i < 10000; i++) begin
         case ($urandom_range(0, 7))
            0:       begin x = 32'hFFFF_FFFF; y = $urandom_range(0, 3); end
            1:       begin x = $urandom; y = ~x; end
            2:       begin x = $urandom; y = (~x) + 32'd1; end
            default: begin x = $urandom; y = $urandom; end
         endcase
         v = 1'($urandom_range(0, 1));
         r = ($urandom_range(0, 199) == 0);
         drive_model(r, v, x, y);
      end

      for (int i = 0; i < 10 && exp_q.size() != 0; i++)
         @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain pending=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout total=%0d", total);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
